// File: rtl/csr_bank_param.sv
// csr_bank_param
//   CSR bank for the HDC core. Decodes the fixed CSR address map behind a
//   valid/ready request/response port. Holds the core mode bits, the N-level
//   loop control fields and the IM seeds. Buffers AM predictions for software,
//   which drains them by reading the predict register.
//
//   Build option CSR_PREDICT_FIFO_EN:
//     defined   - predictions go into a FIFO of PredictFifoDepth entries.
//     undefined - a single holding register. Each new prediction overwrites
//                 the held value, and predict_ready_o is tied high.
//
// Ports
//   clk_i, rst_ni                  clock; asynchronous active-low reset
//   csr_req_*                      request channel (addr, data, write, valid/ready)
//   csr_rsp_*                      response channel (data, valid/ready)
//   start_o, core_clr_o            one-cycle pulses to the core controller
//   busy_i                         core busy; blocks start and mode updates
//   seq_test_o, ima_cim_o          mode bits
//   loop_mode_o                    number of active loops
//   loop_jump_addr_o / loop_end_addr_o / loop_count_o
//                                  packed per-loop fields, loop 0 in the LSBs
//   cim_seed_o, im_base_seed_o     IM seeds
//   predict_i, predict_valid_i, predict_ready_o
//                                  AM prediction input
module csr_bank_param #(
  parameter int unsigned CsrDataWidth     = 32,
  parameter int unsigned CsrAddrWidth     = 32,
  parameter int unsigned NumLoops         = 3,
  parameter int unsigned LoopAddrWidth    = 8,
  parameter int unsigned PredictFifoDepth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [CsrAddrWidth-1:0]           csr_req_addr_i,
  input  logic [CsrDataWidth-1:0]           csr_req_data_i,
  input  logic                              csr_req_write_i,
  input  logic                              csr_req_valid_i,
  output logic                              csr_req_ready_o,
  output logic [CsrDataWidth-1:0]           csr_rsp_data_o,
  output logic                              csr_rsp_valid_o,
  input  logic                              csr_rsp_ready_i,
  output logic                              start_o,
  output logic                              core_clr_o,
  input  logic                              busy_i,
  output logic                              seq_test_o,
  output logic                              ima_cim_o,
  output logic [$clog2(NumLoops+1)-1:0]     loop_mode_o,
  output logic [NumLoops*LoopAddrWidth-1:0] loop_jump_addr_o,
  output logic [NumLoops*LoopAddrWidth-1:0] loop_end_addr_o,
  output logic [NumLoops*LoopAddrWidth-1:0] loop_count_o,
  output logic [CsrDataWidth-1:0]           cim_seed_o,
  output logic [CsrDataWidth-1:0]           im_base_seed_o,
  input  logic [CsrDataWidth-1:0]           predict_i,
  input  logic                              predict_valid_i,
  output logic                              predict_ready_o
);

  localparam int unsigned ModeW = $clog2(NumLoops + 1);
  localparam int unsigned LoopW = NumLoops * LoopAddrWidth;
  localparam int unsigned PtrW  = $clog2(PredictFifoDepth);
  localparam int unsigned CntW  = $clog2(PredictFifoDepth) + 1;

  typedef logic [CsrAddrWidth-1:0] addr_t;
  localparam addr_t AddrCore     = addr_t'(0);
  localparam addr_t AddrNumPred  = addr_t'(1);
  localparam addr_t AddrPredict  = addr_t'(2);
  localparam addr_t AddrLoopMode = addr_t'(9);
  localparam addr_t AddrJump     = addr_t'(10);
  localparam addr_t AddrEnd      = addr_t'(11);
  localparam addr_t AddrCount    = addr_t'(12);
  localparam addr_t AddrCimSeed  = addr_t'(13);
  localparam addr_t AddrImSeed   = addr_t'(14);

  logic                    rsp_valid;
  logic [CsrDataWidth-1:0] rsp_data;
  logic [CsrDataWidth-1:0] rdata;
  logic [CsrDataWidth-1:0] head;
  logic [CntW-1:0]         count;
  logic                    accept, wr, rd, flush, pop, push;

  // Only one request in flight: the port stalls while a response is pending.
  assign csr_req_ready_o = !rsp_valid;
  assign csr_rsp_valid_o = rsp_valid;
  assign csr_rsp_data_o  = rsp_data;

  assign accept = csr_req_valid_i && !rsp_valid;
  assign wr     = accept && csr_req_write_i;
  assign rd     = accept && !csr_req_write_i;
  assign flush  = wr && (csr_req_addr_i == AddrCore) && csr_req_data_i[4];
  assign pop    = rd && (csr_req_addr_i == AddrPredict) && (count != '0);
  assign push   = predict_valid_i && predict_ready_o;

  always_comb begin
    rdata = '0;
    case (csr_req_addr_i)
      AddrCore: begin
        rdata[1] = busy_i;
        rdata[2] = seq_test_o;
        rdata[3] = ima_cim_o;
      end
      AddrNumPred:  rdata = CsrDataWidth'(count);
      AddrPredict:  rdata = head;
      AddrLoopMode: rdata = CsrDataWidth'(loop_mode_o);
      AddrJump:     rdata[LoopW-1:0] = loop_jump_addr_o;
      AddrEnd:      rdata[LoopW-1:0] = loop_end_addr_o;
      AddrCount:    rdata[LoopW-1:0] = loop_count_o;
      AddrCimSeed:  rdata = cim_seed_o;
      AddrImSeed:   rdata = im_base_seed_o;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= csr_req_write_i ? '0 : rdata;
    end else if (csr_rsp_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o          <= 1'b0;
      core_clr_o       <= 1'b0;
      seq_test_o       <= 1'b0;
      ima_cim_o        <= 1'b0;
      loop_mode_o      <= '0;
      loop_jump_addr_o <= '0;
      loop_end_addr_o  <= '0;
      loop_count_o     <= '0;
      cim_seed_o       <= '0;
      im_base_seed_o   <= '0;
    end else begin
      // A start request while the core is busy is dropped, not deferred.
      start_o    <= wr && (csr_req_addr_i == AddrCore) && csr_req_data_i[0] && !busy_i;
      core_clr_o <= flush;
      if (wr) begin
        case (csr_req_addr_i)
          AddrCore: begin
            if (!busy_i) begin
              seq_test_o <= csr_req_data_i[2];
              ima_cim_o  <= csr_req_data_i[3];
            end
          end
          AddrLoopMode: begin
            if (csr_req_data_i > CsrDataWidth'(NumLoops)) loop_mode_o <= ModeW'(NumLoops);
            else                                          loop_mode_o <= csr_req_data_i[ModeW-1:0];
          end
          AddrJump:    loop_jump_addr_o <= csr_req_data_i[LoopW-1:0];
          AddrEnd:     loop_end_addr_o  <= csr_req_data_i[LoopW-1:0];
          AddrCount:   loop_count_o     <= csr_req_data_i[LoopW-1:0];
          AddrCimSeed: cim_seed_o       <= csr_req_data_i;
          AddrImSeed:  im_base_seed_o   <= csr_req_data_i;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_PREDICT_FIFO_EN
  logic [CsrDataWidth-1:0] mem [PredictFifoDepth];
  logic [PtrW-1:0]         rd_ptr, wr_ptr;

  assign head = (count != '0) ? mem[rd_ptr] : '0;
  // Ready comes only from the stored count: a full FIFO refuses a push even
  // when software pops in the same cycle.
  assign predict_ready_o = (count != CntW'(PredictFifoDepth));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= predict_i;
  end
`else
  logic [CsrDataWidth-1:0] held;

  // held is zeroed whenever the count drops to 0, so an empty read returns 0.
  assign head            = held;
  assign predict_ready_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held  <= '0;
      count <= '0;
    end else if (flush) begin
      held  <= '0;
      count <= '0;
    end else if (push) begin
      held  <= predict_i;
      count <= CntW'(1);
    end else if (pop) begin
      held  <= '0;
      count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_csr_bank_param.sv
module tb_csr_bank_param;
  localparam int DW = 32, AW = 32, NL = 3, LW = 8, DEPTH = 4, MW = 2;
`ifdef CSR_PREDICT_FIFO_EN
  localparam bit FifoMode = 1'b1;
`else
  localparam bit FifoMode = 1'b0;
`endif

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [AW-1:0] csr_req_addr_i = '0;
  logic [DW-1:0] csr_req_data_i = '0;
  logic csr_req_write_i = 1'b0, csr_req_valid_i = 1'b0, csr_req_ready_o;
  logic [DW-1:0] csr_rsp_data_o;
  logic csr_rsp_valid_o, csr_rsp_ready_i = 1'b1;
  logic start_o, core_clr_o, busy_i = 1'b0, seq_test_o, ima_cim_o;
  logic [MW-1:0] loop_mode_o;
  logic [NL*LW-1:0] loop_jump_addr_o, loop_end_addr_o, loop_count_o;
  logic [DW-1:0] cim_seed_o, im_base_seed_o, predict_i = '0;
  logic predict_valid_i = 1'b0, predict_ready_o;

  csr_bank_param #(.CsrDataWidth(DW), .CsrAddrWidth(AW), .NumLoops(NL),
                   .LoopAddrWidth(LW), .PredictFifoDepth(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_req_addr_i(csr_req_addr_i), .csr_req_data_i(csr_req_data_i),
    .csr_req_write_i(csr_req_write_i), .csr_req_valid_i(csr_req_valid_i),
    .csr_req_ready_o(csr_req_ready_o), .csr_rsp_data_o(csr_rsp_data_o),
    .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rsp_ready_i(csr_rsp_ready_i),
    .start_o(start_o), .core_clr_o(core_clr_o), .busy_i(busy_i),
    .seq_test_o(seq_test_o), .ima_cim_o(ima_cim_o), .loop_mode_o(loop_mode_o),
    .loop_jump_addr_o(loop_jump_addr_o), .loop_end_addr_o(loop_end_addr_o),
    .loop_count_o(loop_count_o), .cim_seed_o(cim_seed_o),
    .im_base_seed_o(im_base_seed_o), .predict_i(predict_i),
    .predict_valid_i(predict_valid_i), .predict_ready_o(predict_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // Reference model: plain register values plus a queue of pending predictions.
  logic [DW-1:0]    q[$];
  logic             m_seq, m_ima;
  logic [MW-1:0]    m_mode;
  logic [NL*LW-1:0] m_jump, m_end, m_cnt;
  logic [DW-1:0]    m_cim, m_im;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0; m_ima = 0; m_mode = '0;
    m_jump = '0; m_end = '0; m_cnt = '0; m_cim = '0; m_im = '0;
  endtask

  function automatic bit model_ready();
    return FifoMode ? (q.size() != DEPTH) : 1'b1;
  endfunction

  task automatic model_push(input logic [DW-1:0] v);
    if (FifoMode) begin
      if (q.size() < DEPTH) q.push_back(v);
    end else begin
      q.delete();
      q.push_back(v);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic busy);
    logic [DW-1:0] r;
    r = '0;
    case (a)
      0:  begin r[1] = busy; r[2] = m_seq; r[3] = m_ima; end
      1:  r = DW'(q.size());
      2:  r = (q.size() > 0) ? q[0] : '0;
      9:  r = DW'(m_mode);
      10: r = DW'(m_jump);
      11: r = DW'(m_end);
      12: r = DW'(m_cnt);
      13: r = m_cim;
      14: r = m_im;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_outputs();
    check("seq_test", seq_test_o, m_seq);
    check("ima_cim", ima_cim_o, m_ima);
    check("loop_mode", loop_mode_o, m_mode);
    check("loop_jump", loop_jump_addr_o, m_jump);
    check("loop_end", loop_end_addr_o, m_end);
    check("loop_count", loop_count_o, m_cnt);
    check("cim_seed", cim_seed_o, m_cim);
    check("im_seed", im_base_seed_o, m_im);
    check("predict_ready", predict_ready_o, model_ready());
  endtask

  // One complete CSR transaction with immediate response acceptance,
  // optionally with a prediction offered in the acceptance cycle.
  task automatic csr_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit do_push, input logic [DW-1:0] pv);
    logic [DW-1:0] exp_rd;
    bit rdy, flush, exp_start, exp_clr;
    check("req_ready_idle", csr_req_ready_o, 1);
    rdy = model_ready();
    exp_rd = wr ? '0 : model_read(a, busy_i);
    csr_req_valid_i = 1; csr_req_write_i = wr; csr_req_addr_i = a; csr_req_data_i = d;
    predict_valid_i = do_push; predict_i = pv;
    @(posedge clk_i); #1;
    csr_req_valid_i = 0; predict_valid_i = 0;
    flush = 0; exp_start = 0; exp_clr = 0;
    if (wr) begin
      case (a)
        0: begin
          exp_start = d[0] && !busy_i;
          exp_clr = d[4];
          if (!busy_i) begin m_seq = d[2]; m_ima = d[3]; end
          if (d[4]) begin flush = 1; q.delete(); end
        end
        9:  m_mode = (d > NL) ? MW'(NL) : d[MW-1:0];
        10: m_jump = d[NL*LW-1:0];
        11: m_end  = d[NL*LW-1:0];
        12: m_cnt  = d[NL*LW-1:0];
        13: m_cim  = d;
        14: m_im   = d;
        default: ;
      endcase
    end else if (a == 2 && q.size() > 0) begin
      void'(q.pop_front());
    end
    if (do_push && rdy && !flush) model_push(pv);
    check("rsp_valid", csr_rsp_valid_o, 1);
    check(wr ? "wr_rsp_data" : "rd_rsp_data", csr_rsp_data_o, exp_rd);
    check("start_pulse", start_o, exp_start);
    check("clr_pulse", core_clr_o, exp_clr);
    check_outputs();
    @(posedge clk_i); #1;
    check("rsp_done", csr_rsp_valid_o, 0);
    check("start_low", start_o, 0);
    check("clr_low", core_clr_o, 0);
  endtask

  task automatic push_pred(input logic [DW-1:0] v);
    bit rdy;
    rdy = model_ready();
    check("pred_ready_pre", predict_ready_o, rdy);
    predict_valid_i = 1; predict_i = v;
    @(posedge clk_i); #1;
    predict_valid_i = 0;
    if (rdy) model_push(v);
  endtask

  initial begin
    logic [DW-1:0] hold_data, seed;
    model_reset();
    #12;
    // reset state
    check("rst_req_ready", csr_req_ready_o, 1);
    check("rst_rsp_valid", csr_rsp_valid_o, 0);
    check("rst_start", start_o, 0);
    check("rst_clr", core_clr_o, 0);
    check_outputs();
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
    csr_op(0, 0, '0, 0, '0);

    // loop fields and readback
    csr_op(1, 10, 32'h000B_0A05, 0, '0);
    check("jump_value", loop_jump_addr_o, 24'h0B0A05);
    csr_op(0, 10, '0, 0, '0);
    csr_op(1, 11, 32'hFF12_3456, 0, '0);
    csr_op(0, 11, '0, 0, '0);

    // start gating on busy
    busy_i = 0; csr_op(1, 0, 32'h1, 0, '0);
    busy_i = 1; csr_op(1, 0, 32'hD, 0, '0);
    csr_op(0, 0, '0, 0, '0);
    busy_i = 0; csr_op(1, 0, 32'hC, 0, '0);

    // fill past depth, then drain
    for (int i = 0; i < 5; i++) push_pred(DW'(32'h11 + i));
    check_outputs();
    csr_op(0, 1, '0, 0, '0);
    for (int i = 0; i < 5; i++) csr_op(0, 2, '0, 0, '0);
    csr_op(0, 1, '0, 0, '0);

    // loop mode saturation and flush beating a push
    csr_op(1, 9, 32'd7, 0, '0);
    check("mode_sat", loop_mode_o, 2'd3);
    csr_op(1, 9, 32'd2, 0, '0);
    push_pred(32'hA1); push_pred(32'hA2);
    csr_op(1, 0, 32'h10, 1, 32'hA3);
    csr_op(0, 1, '0, 0, '0);

    // full FIFO: a pop with a same-cycle push must refuse the push
    for (int i = 0; i < 4; i++) push_pred(DW'(32'hB0 + i));
    csr_op(0, 2, '0, 1, 32'hBF);
    csr_op(0, 1, '0, 0, '0);
    csr_op(0, 2, '0, 1, 32'hC0);
    csr_op(0, 1, '0, 0, '0);

    // response back-pressure with a second request waiting
    seed = $urandom;
    csr_req_valid_i = 1; csr_req_write_i = 0; csr_req_addr_i = 11;
    csr_rsp_ready_i = 0;
    @(posedge clk_i); #1;
    hold_data = model_read(11, busy_i);
    csr_req_write_i = 1; csr_req_addr_i = 13; csr_req_data_i = seed;
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp_valid", csr_rsp_valid_o, 1);
      check("bp_rsp_data", csr_rsp_data_o, hold_data);
      check("bp_req_ready", csr_req_ready_o, 0);
      check("bp_seed_old", cim_seed_o, m_cim);
      @(posedge clk_i); #1;
    end
    csr_rsp_ready_i = 1;
    @(posedge clk_i); #1;
    check("bp_rsp_drop", csr_rsp_valid_o, 0);
    check("bp_req_ready_back", csr_req_ready_o, 1);
    check("bp_seed_still_old", cim_seed_o, m_cim);
    @(posedge clk_i); #1;
    csr_req_valid_i = 0;
    m_cim = seed;
    check("bp_second_accept", csr_rsp_valid_o, 1);
    check("bp_seed_new", cim_seed_o, m_cim);
    @(posedge clk_i); #1;

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int op;
      op = $urandom_range(0, 3);
      busy_i = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      d = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 5));
      case (op)
        0: csr_op(1, a, d, $urandom_range(0, 1) == 1, DW'($urandom));
        1: csr_op(0, a, '0, $urandom_range(0, 1) == 1, DW'($urandom));
        2: push_pred(DW'($urandom));
        default: csr_op(0, 2, '0, $urandom_range(0, 1) == 1, DW'($urandom));
      endcase
    end
    busy_i = 0;

    // asynchronous reset with a pending response and a non-empty FIFO
    push_pred(32'hE1); push_pred(32'hE2);
    csr_op(1, 14, 32'h1234_5678, 0, '0);
    csr_rsp_ready_i = 0;
    csr_req_valid_i = 1; csr_req_write_i = 0; csr_req_addr_i = 14;
    @(posedge clk_i); #1;
    csr_req_valid_i = 0;
    check("pre_rst_rsp_valid", csr_rsp_valid_o, 1);
    #2 rst_ni = 0;
    #1;
    model_reset();
    check("arst_rsp_valid", csr_rsp_valid_o, 0);
    check("arst_req_ready", csr_req_ready_o, 1);
    check("arst_rsp_data", csr_rsp_data_o, 0);
    check_outputs();
    csr_rsp_ready_i = 1;
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
    csr_op(0, 1, '0, 0, '0);
    csr_op(0, 2, '0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
